axi_llc_desc_arb: RTL and testbench
===================================

AXI_LLC_DESC_ARB -- requirements
Module: axi_llc_desc_arb

Interface
REQ-001 SHALL have parameter DescWidth, default 64, width of one descriptor bit vector.
REQ-002 SHALL have parameter FlushMax, default 8, maximum consecutive flush grants while a read or write descriptor is waiting.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports flush_desc_i  input  DescWidth, flush_valid_i  input  1, flush_ready_o  output  1: flush descriptor channel.
REQ-006 SHALL have ports w_desc_i  input  DescWidth, w_valid_i  input  1, w_ready_o  output  1: write-chunk descriptor channel.
REQ-007 SHALL have ports r_desc_i  input  DescWidth, r_valid_i  input  1, r_ready_o  output  1: read-chunk descriptor channel.
REQ-008 SHALL have ports desc_o  output  DescWidth, valid_o  output  1, ready_i  input  1: descriptor stream to the hit/miss unit.
REQ-009 SHALL have port src_o  output  2  source of desc_o: 0 read, 1 write, 2 flush; 3 never driven.
REQ-010 SHALL have port idle_o  output  1  high when valid_o low and all three input valids low.

Function
REQ-011 SHALL hold one output register (desc_o, src_o, valid_o); load_en = !valid_o || ready_i.
REQ-012 SHALL, when load_en and at least one input valid, grant exactly one input, capture its descriptor and source, set valid_o next cycle; latency input handshake -> valid_o is 1 cycle.
REQ-013 SHALL clear valid_o on a cycle with ready_i high and no grant; SHALL hold desc_o/src_o stable while valid_o && !ready_i.
REQ-014 SHALL assert x_ready_o only for the granted input and only when load_en; ready outputs may depend on input valids but no valid_o may depend on a ready in the same path.
REQ-015 SHALL give flush priority over read and write, except when the starvation counter equals FlushMax.
REQ-016 SHALL keep a starvation counter (width clog2(FlushMax+1)): +1 per flush grant while r_valid_i or w_valid_i high; reset to 0 on any read/write grant or when neither r_valid_i nor w_valid_i is high; saturates at FlushMax.
REQ-017 SHALL, when counter == FlushMax and a read/write is valid, grant read/write over flush for that cycle.
REQ-018 SHALL arbitrate read vs write round-robin using a last-grant bit: if both valid, grant the one not granted last; if one valid, grant it; update bit only on read/write grants.
REQ-019 SHALL sustain one descriptor per cycle with ready_i held high.
REQ-020 SHALL never drop, duplicate or reorder descriptors within one source channel.
REQ-021 SHALL tolerate input valid deassertion without handshake (no grant state carried across cycles except counter and last-grant bit).

Reset
REQ-022 SHALL, while rst_i high, force valid_o=0, desc_o=0, src_o=0, starvation counter=0, last-grant bit=write (read wins first tie); idle_o follows input valids combinationally.
REQ-023 SHALL discard a held descriptor on reset mid-operation; all ready outputs 0 while rst_i high.
REQ-024 SHALL resume normal arbitration on the first rising edge after rst_i falls.

Verification
REQ-025 Tie: after reset, r_valid_i=w_valid_i=1 for 4 cycles, ready_i=1 -> src_o sequence 0,1,0,1; desc_o matches the respective input each cycle.
REQ-026 Backpressure: valid_o=1, ready_i=0 for 3 cycles with all inputs valid -> desc_o/src_o unchanged, all ready outputs 0; ready_i=1 -> next descriptor loaded the same edge.
REQ-027 Flush priority/starvation: FlushMax=8, flush_valid_i and r_valid_i held 1, ready_i=1 -> 8 flush grants (src_o=2), then 1 read (src_o=0), then flushes again.
REQ-028 Single source: only w_valid_i=1 with w_desc_i=0x1 incrementing per handshake for 10 cycles -> desc_o 0x1..0xA consecutively, src_o=1, no bubbles.
REQ-029 Reset mid-stream: valid_o=1, ready_i=0, assert rst_i asynchronously between edges -> valid_o, desc_o, src_o go 0 immediately; after release, a tie grants read first.
REQ-030 Idle: all input valids 0, ready_i=1 for 2 cycles after traffic -> valid_o=0, idle_o=1 on second cycle.

Source files
------------

// File: rtl/axi_llc_desc_arb_if.sv
// Descriptor bundle between the three LLC descriptor sources and the hit/miss unit.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface axi_llc_desc_arb_if #(
    parameter int DescWidth = 64
);
    logic [DescWidth-1:0] flush_desc_i;
    logic                 flush_valid_i;
    logic                 flush_ready_o;
    logic [DescWidth-1:0] w_desc_i;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [DescWidth-1:0] r_desc_i;
    logic                 r_valid_i;
    logic                 r_ready_o;
    logic [DescWidth-1:0] desc_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [1:0]           src_o;
    logic                 idle_o;

    modport slave (
        input  flush_desc_i, flush_valid_i, w_desc_i, w_valid_i,
               r_desc_i, r_valid_i, ready_i,
        output flush_ready_o, w_ready_o, r_ready_o, desc_o, valid_o,
               src_o, idle_o
    );

    modport master (
        output flush_desc_i, flush_valid_i, w_desc_i, w_valid_i,
               r_desc_i, r_valid_i, ready_i,
        input  flush_ready_o, w_ready_o, r_ready_o, desc_o, valid_o,
               src_o, idle_o
    );
endinterface

// File: rtl/axi_llc_desc_arb.sv
// Three-way descriptor arbiter: the flush source has priority, bounded by a starvation counter; read and write alternate round-robin.
// A grant reaches valid_o after 1 cycle; one output register stalls all inputs while valid_o && !ready_i.
module axi_llc_desc_arb #(
    parameter int DescWidth = 64,
    parameter int FlushMax  = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    axi_llc_desc_arb_if.slave bus
);
    localparam int CntW = $clog2(FlushMax + 1);

    logic [DescWidth-1:0] desc_q;
    logic [1:0]           src_q;
    logic                 valid_q;
    logic [CntW-1:0]      starve_cnt;
    logic                 last_w;

    logic load_en, any_rw, starved, gnt_f, gnt_r, gnt_w, gnt_any;

    always_comb begin
        load_en = !valid_q || bus.ready_i;
        any_rw  = bus.r_valid_i || bus.w_valid_i;
        starved = (starve_cnt == CntW'(FlushMax)) && any_rw;
        gnt_f   = bus.flush_valid_i && !starved;
        // last_w set means write went last, so read wins the next tie.
        gnt_r   = !gnt_f && bus.r_valid_i && (!bus.w_valid_i || last_w);
        gnt_w   = !gnt_f && bus.w_valid_i && !gnt_r;
        gnt_any = gnt_f || gnt_r || gnt_w;
    end

    assign bus.flush_ready_o = gnt_f && load_en && !rst_i;
    assign bus.w_ready_o     = gnt_w && load_en && !rst_i;
    assign bus.r_ready_o     = gnt_r && load_en && !rst_i;
    assign bus.desc_o        = desc_q;
    assign bus.src_o         = src_q;
    assign bus.valid_o       = valid_q;
    assign bus.idle_o        = !valid_q && !bus.flush_valid_i
                               && !bus.w_valid_i && !bus.r_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            desc_q     <= '0;
            src_q      <= 2'd0;
            valid_q    <= 1'b0;
            starve_cnt <= '0;
            last_w     <= 1'b1;
        end else begin
            if (!any_rw) begin
                starve_cnt <= '0;
            end else if (load_en && (gnt_r || gnt_w)) begin
                starve_cnt <= '0;
            end else if (load_en && gnt_f && (starve_cnt != CntW'(FlushMax))) begin
                starve_cnt <= starve_cnt + CntW'(1);
            end

            if (load_en && (gnt_r || gnt_w)) begin
                last_w <= gnt_w;
            end

            if (load_en) begin
                valid_q <= gnt_any;
                if (gnt_any) begin
                    desc_q <= gnt_f ? bus.flush_desc_i :
                              gnt_w ? bus.w_desc_i : bus.r_desc_i;
                    src_q  <= gnt_f ? 2'd2 : gnt_w ? 2'd1 : 2'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_llc_desc_arb.sv
// Directed bench for axi_llc_desc_arb: tie round-robin, backpressure, flush starvation, single source, reset, idle.
module tb_axi_llc_desc_arb;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_llc_desc_arb_if #(.DescWidth(64)) bus ();

    axi_llc_desc_arb #(.DescWidth(64), .FlushMax(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus.flush_desc_i  = '0;
        bus.flush_valid_i = 1'b0;
        bus.w_desc_i      = '0;
        bus.w_valid_i     = 1'b0;
        bus.r_desc_i      = '0;
        bus.r_valid_i     = 1'b0;
        bus.ready_i       = 1'b1;

        // Reset state
        tick();
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_desc", bus.desc_o, 64'd0);
        chk("rst_src", 64'(bus.src_o), 64'd0);
        chk("rst_idle", 64'(bus.idle_o), 64'd1);
        bus.r_valid_i = 1'b1;
        #1;
        chk("rst_r_ready", 64'(bus.r_ready_o), 64'd0);
        chk("rst_idle_follow", 64'(bus.idle_o), 64'd0);
        bus.r_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;

        // Tie: read first, then alternate
        bus.r_valid_i = 1'b1;
        bus.w_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.r_desc_i = 64'h100 + 64'(i);
            bus.w_desc_i = 64'h200 + 64'(i);
            #1;
            chk("tie_r_ready", 64'(bus.r_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("tie_w_ready", 64'(bus.w_ready_o), (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            chk("tie_valid", 64'(bus.valid_o), 64'd1);
            chk("tie_src", 64'(bus.src_o), (i % 2 == 0) ? 64'd0 : 64'd1);
            chk("tie_desc", bus.desc_o, (i % 2 == 0) ? 64'h100 + 64'(i) : 64'h200 + 64'(i));
        end

        // Backpressure with every input valid
        bus.ready_i       = 1'b0;
        bus.flush_valid_i = 1'b1;
        bus.flush_desc_i  = 64'hF0;
        #1;
        chk("bp_f_ready", 64'(bus.flush_ready_o), 64'd0);
        chk("bp_r_ready", 64'(bus.r_ready_o), 64'd0);
        chk("bp_w_ready", 64'(bus.w_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_desc", bus.desc_o, 64'h203);
            chk("bp_hold_src", 64'(bus.src_o), 64'd1);
            chk("bp_hold_valid", 64'(bus.valid_o), 64'd1);
        end
        bus.ready_i = 1'b1;
        #1;
        chk("bp_release_f_ready", 64'(bus.flush_ready_o), 64'd1);
        tick();
        chk("bp_release_src", 64'(bus.src_o), 64'd2);
        chk("bp_release_desc", bus.desc_o, 64'hF0);

        // Idle after traffic
        bus.flush_valid_i = 1'b0;
        bus.r_valid_i     = 1'b0;
        bus.w_valid_i     = 1'b0;
        tick();
        tick();
        chk("idle_valid", 64'(bus.valid_o), 64'd0);
        chk("idle_flag", 64'(bus.idle_o), 64'd1);

        // Flush starvation limit: 8 flushes, 1 read, then flush again
        bus.flush_valid_i = 1'b1;
        bus.r_valid_i     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.flush_desc_i = 64'h300 + 64'(i);
            bus.r_desc_i     = 64'h400 + 64'(i);
            tick();
            chk("starve_src", 64'(bus.src_o), (i == 8) ? 64'd0 : 64'd2);
            chk("starve_desc", bus.desc_o, (i == 8) ? 64'h400 + 64'(i) : 64'h300 + 64'(i));
        end
        bus.flush_valid_i = 1'b0;
        bus.r_valid_i     = 1'b0;
        tick();

        // Single write source, one per cycle, no bubbles
        bus.w_valid_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.w_desc_i = 64'(i);
            tick();
            chk("single_valid", 64'(bus.valid_o), 64'd1);
            chk("single_src", 64'(bus.src_o), 64'd1);
            chk("single_desc", bus.desc_o, 64'(i));
        end
        bus.w_valid_i = 1'b0;
        tick();

        // Asynchronous reset while a descriptor is held
        bus.r_valid_i = 1'b1;
        bus.r_desc_i  = 64'h55;
        bus.ready_i   = 1'b0;
        tick();
        chk("mid_loaded", bus.desc_o, 64'h55);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
        chk("mid_rst_desc", bus.desc_o, 64'd0);
        chk("mid_rst_src", 64'(bus.src_o), 64'd0);
        chk("mid_rst_r_ready", 64'(bus.r_ready_o), 64'd0);
        tick();
        rst_i         = 1'b0;
        bus.ready_i   = 1'b1;
        bus.w_valid_i = 1'b1;
        bus.r_desc_i  = 64'hA1;
        bus.w_desc_i  = 64'hB1;
        tick();
        chk("post_rst_src0", 64'(bus.src_o), 64'd0);
        chk("post_rst_desc0", bus.desc_o, 64'hA1);
        tick();
        chk("post_rst_src1", 64'(bus.src_o), 64'd1);
        chk("post_rst_desc1", bus.desc_o, 64'hB1);
        bus.r_valid_i = 1'b0;
        bus.w_valid_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
